cs_accumulator: RTL and testbench
=================================

Name: cs_accumulator

Overview:
- Receive end of the dot-product array's carry-save output pair (sum, carry).
- Resolves each pair to a binary value with a carry-propagate add, sign-extends it, and accumulates over a programmed number of beats (one dot-product tile per beat).
- Returns one resolved accumulated result per job on a valid/ready output, with an overflow flag.
- Sits between the array output registers and the result writeback path.

Parameters:
- IN_SIZE, 26: width of each carry-save input word; matches the array output width at default array settings.
- ACC_SIZE, 32: accumulator and result width; must be >= IN_SIZE.
- LEN_SIZE, 8: width of the beat-count field.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  job start pulse; sampled only in IDLE.
- len_i  in  LEN_SIZE  number of beats in the job; latched when start_i is accepted.
- busy_o  out  1  high in ACC and OUT states.
- in_valid_i  in  1  carry-save pair valid.
- in_ready_o  out  1  high only in ACC state.
- in_sum_i  in  IN_SIZE  sum vector.
- in_carry_i  in  IN_SIZE  carry vector, already weight-aligned with sum.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumer ready.
- out_data_o  out  ACC_SIZE  accumulated signed result.
- out_ovf_o  out  1  sticky signed overflow for the job; valid with out_valid_o.

Behaviour:
- Reset: state=IDLE; acc, beat counter, out_data_o, out_ovf_o, out_valid_o, in_ready_o and busy_o all 0. Reset asserted mid-job aborts the job immediately; no result is emitted.
- Beat value: v = sign_extend_ACC_SIZE((in_sum_i + in_carry_i) mod 2^IN_SIZE). The resolved IN_SIZE word is two's complement. The carry out of the IN_SIZE-bit add is discarded.
- FSM:
  - IDLE: if start_i=1, latch len_i, clear acc, counter and ovf. If len_i=0, go to OUT with result 0 and ovf 0; otherwise go to ACC. start_i in any other state is ignored.
  - ACC: in_ready_o=1. A beat is accepted when in_valid_i=1: acc <= acc+v, counter++. When the accepted beat is number len (counter==len-1), go to OUT.
  - OUT: out_valid_o=1; out_data_o and out_ovf_o hold stable. When out_ready_i=1, go to IDLE. A start_i in the same cycle is ignored; start is accepted from the next cycle.
- Latency: out_valid_o rises on the cycle after the final beat is accepted. Throughput is one beat per cycle in ACC.
- Overflow: signed overflow of acc+v (operands same sign, result different sign) sets the sticky ovf bit. Default behaviour is wrap-around (mod 2^ACC_SIZE).
- in_valid_i outside ACC: ignored, no state change; in_ready_o=0.
- out_data_o is driven from the acc register (registered output, no combinational path from inputs).

Optional Feature:
- Macro: CS_ACCUMULATOR_SATURATE_EN
- Defined: on overflow, acc clamps to 2^(ACC_SIZE-1)-1 (positive) or -2^(ACC_SIZE-1) (negative). Subsequent beats continue from the clamped value. out_ovf_o is still set.
- Undefined: wrap-around as above; out_ovf_o is still set.

Test Plan:
- Basic job: len=3; beats (sum,carry)=(5,3),(10,-2 as 26-bit),(0,1) -> out_data_o=17, out_ovf_o=0; out_valid_o one cycle after 3rd accept.
- Carry-save resolve: sum=0x2000000, carry=0x2000000 (26-bit) -> resolved 0 (carry discarded); len=1 -> out_data_o=0.
- Backpressure: len=2; in_valid_i gapped 3 cycles between beats; out_ready_i held low 5 cycles -> out_data_o stable; single result; then IDLE and busy_o=0.
- Overflow: ACC_SIZE=32; 130 beats each resolving to 0x1FFFFFF (33554431) -> sum 4362076030 exceeds 2^31-1. Without macro: result wraps to 67108734, out_ovf_o=1. With macro: 2147483647, out_ovf_o=1.
- len_i=0 start -> OUT next cycle, out_data_o=0, out_ovf_o=0; in_ready_o never asserted.
- rst_i asserted after 2 of 4 beats -> all outputs 0, IDLE. A new len=1 job with (7,0) -> out_data_o=7.

Source files
------------

// File: rtl/cs_accumulator.sv
// Resolves carry-save (sum, carry) beats, sign-extends, and accumulates one result per job.
// Optional CS_ACCUMULATOR_SATURATE_EN clamps the accumulator on signed overflow instead of wrapping.
module cs_accumulator #(
  parameter int IN_SIZE  = 26,
  parameter int ACC_SIZE = 32,
  parameter int LEN_SIZE = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [LEN_SIZE-1:0] len_i,
  output logic                busy_o,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_sum_i,
  input  logic [IN_SIZE-1:0]  in_carry_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] out_data_o,
  output logic                out_ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  state_e              state_q, state_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [LEN_SIZE-1:0] cnt_q, cnt_d;
  logic [LEN_SIZE-1:0] len_q, len_d;
  logic                ovf_q, ovf_d;

  logic [IN_SIZE-1:0]  resolved;
  logic [ACC_SIZE-1:0] beat_val;
  logic [ACC_SIZE-1:0] sum_val;
  logic [ACC_SIZE-1:0] acc_beat;
  logic                beat_ovf;
  logic                beat_fire;
  logic                last_beat;

  // Carry out of the IN_SIZE-bit add is dropped; the resolved word is two's complement.
  always_comb begin
    resolved  = in_sum_i + in_carry_i;
    beat_val  = ACC_SIZE'($signed(resolved));
    sum_val   = acc_q + beat_val;
    beat_ovf  = (acc_q[ACC_SIZE-1] == beat_val[ACC_SIZE-1]) &&
                (sum_val[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);
`ifdef CS_ACCUMULATOR_SATURATE_EN
    if (beat_ovf) begin
      acc_beat = acc_q[ACC_SIZE-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_beat = sum_val;
    end
`else
    acc_beat  = sum_val;
`endif
    beat_fire = (state_q == S_ACC) && in_valid_i;
    last_beat = (cnt_q == (len_q - LEN_SIZE'(1)));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d = len_i;
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          state_d = (len_i == '0) ? S_OUT : S_ACC;
        end
      end
      S_ACC: begin
        if (beat_fire) begin
          acc_d = acc_beat;
          cnt_d = cnt_q + LEN_SIZE'(1);
          ovf_d = ovf_q | beat_ovf;
          if (last_beat) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs decode directly from registers.
  assign busy_o      = (state_q != S_IDLE);
  assign in_ready_o  = (state_q == S_ACC);
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = acc_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_cs_accumulator.sv
// Directed self-checking bench for cs_accumulator with hand-computed expectations.
module tb_cs_accumulator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  len_i = '0;
  logic        busy_o;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [25:0] in_sum_i = '0;
  logic [25:0] in_carry_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic        out_ovf_o;

  int n_checks = 0;
  int n_fail   = 0;

  cs_accumulator #(.IN_SIZE(26), .ACC_SIZE(32), .LEN_SIZE(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_sum_i(in_sum_i),
    .in_carry_i(in_carry_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ovf_o(out_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [7:0] l);
    start_i = 1'b1;
    len_i   = l;
    tick();
    start_i = 1'b0;
  endtask

  // Holds valid until the beat is accepted; ok=0 if the DUT never becomes ready.
  task automatic send_beat(input logic [25:0] s, input logic [25:0] c, output bit ok);
    ok = 1'b0;
    in_valid_i = 1'b1;
    in_sum_i   = s;
    in_carry_i = c;
    for (int i = 0; i < 50; i++) begin
      if (in_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b1;
    tick(); tick();
    n_checks++; if (out_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", out_data_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", in_ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_checks++; if (out_ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", out_ovf_o); end
    rst_i = 1'b0;
    tick(); tick();
    n_checks++; if (busy_o !== 1'b0 || out_data_o !== 32'd0) begin n_fail++; $display("FAIL idle_valid_ignored busy %b data %0h exp 0/0", busy_o, out_data_o); end
    in_valid_i = 1'b0;
  endtask

  task automatic test_basic();
    bit ok0, ok1, ok2;
    start_job(8'd3);
    send_beat(26'd5, 26'd3, ok0);
    send_beat(26'd10, 26'h3FFFFFE, ok1);
    send_beat(26'd0, 26'd1, ok2);
    n_checks++; if (!(ok0 && ok1 && ok2)) begin n_fail++; $display("FAIL basic_accept got %b%b%b exp 111", ok0, ok1, ok2); end
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency valid %b exp 1", out_valid_o); end
    n_checks++; if (out_data_o !== 32'd17) begin n_fail++; $display("FAIL basic_data got %0d exp 17", out_data_o); end
    n_checks++; if (out_ovf_o !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b exp 0", out_ovf_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_drain valid %b busy %b exp 0 0", out_valid_o, busy_o); end
  endtask

  task automatic test_resolve();
    bit ok0, ok1, ok2;
    start_job(8'd1);
    send_beat(26'h2000000, 26'h2000000, ok0);
    n_checks++; if (!ok0 || out_valid_o !== 1'b1 || out_data_o !== 32'd0) begin n_fail++; $display("FAIL resolve_carry_drop data %0h valid %b exp 0 1", out_data_o, out_valid_o); end
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    // -1 + -2 checks sign extension of negative resolved words.
    start_job(8'd2);
    send_beat(26'h3FFFFFF, 26'd0, ok1);
    send_beat(26'd0, 26'h3FFFFFE, ok2);
    n_checks++; if (!(ok1 && ok2) || out_data_o !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL resolve_negative got %0h exp fffffffd", out_data_o); end
    n_checks++; if (out_ovf_o !== 1'b0) begin n_fail++; $display("FAIL resolve_negative_ovf got %b exp 0", out_ovf_o); end
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok0, ok1;
    start_job(8'd2);
    send_beat(26'd100, 26'd20, ok0);
    for (int i = 0; i < 3; i++) begin
      start_i = 1'b1; len_i = 8'd5;
      n_checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_gap%0d ready %b valid %b exp 1 0", i, in_ready_o, out_valid_o); end
      tick();
    end
    start_i = 1'b0;
    send_beat(26'h3FFFFFF, 26'h3FFFFFF, ok1);
    n_checks++; if (!(ok0 && ok1) || out_valid_o !== 1'b1 || out_data_o !== 32'd118) begin n_fail++; $display("FAIL bp_result data %0d valid %b exp 118 1", out_data_o, out_valid_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'd118) begin n_fail++; $display("FAIL bp_hold%0d data %0d valid %b exp 118 1", i, out_data_o, out_valid_o); end
    end
    out_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd1;
    tick();
    out_ready_i = 1'b0; start_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_release valid %b busy %b exp 0 0", out_valid_o, busy_o); end
    tick();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored busy %b exp 0", busy_o); end
  endtask

  task automatic test_overflow();
    bit ok;
    int n_ok = 0;
    logic [31:0] exp_data;
`ifdef CS_ACCUMULATOR_SATURATE_EN
    exp_data = 32'h7FFFFFFF;
`else
    exp_data = 32'd67108734;
`endif
    start_job(8'd130);
    for (int i = 0; i < 130; i++) begin
      send_beat(26'h1FFFFFF, 26'd0, ok);
      if (ok) n_ok++;
    end
    n_checks++; if (n_ok != 130) begin n_fail++; $display("FAIL ovf_accept got %0d exp 130", n_ok); end
    n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== exp_data) begin n_fail++; $display("FAIL ovf_data got %0d valid %b exp %0d 1", out_data_o, out_valid_o, exp_data); end
    n_checks++; if (out_ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", out_ovf_o); end
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
  endtask

  task automatic test_len_zero();
    start_job(8'd0);
    n_checks++; if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL len0_valid valid %b busy %b exp 1 1", out_valid_o, busy_o); end
    n_checks++; if (out_data_o !== 32'd0 || out_ovf_o !== 1'b0) begin n_fail++; $display("FAIL len0_result data %0h ovf %b exp 0 0", out_data_o, out_ovf_o); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL len0_ready%0d got %b exp 0", i, in_ready_o); end
      tick();
    end
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    n_checks++; if (in_ready_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL len0_done ready %b busy %b exp 0 0", in_ready_o, busy_o); end
  endtask

  task automatic test_reset_midjob();
    bit ok0, ok1, ok2;
    start_job(8'd4);
    send_beat(26'd3, 26'd0, ok0);
    send_beat(26'd4, 26'd0, ok1);
    n_checks++; if (!(ok0 && ok1) || out_data_o !== 32'd7) begin n_fail++; $display("FAIL midjob_partial got %0d exp 7", out_data_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++; if (out_data_o !== 32'd0 || out_valid_o !== 1'b0 || out_ovf_o !== 1'b0) begin n_fail++; $display("FAIL midjob_outputs data %0h valid %b ovf %b exp 0 0 0", out_data_o, out_valid_o, out_ovf_o); end
    n_checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL midjob_idle busy %b ready %b exp 0 0", busy_o, in_ready_o); end
    start_job(8'd1);
    send_beat(26'd7, 26'd0, ok2);
    n_checks++; if (!ok2 || out_valid_o !== 1'b1 || out_data_o !== 32'd7) begin n_fail++; $display("FAIL midjob_newjob data %0d valid %b exp 7 1", out_data_o, out_valid_o); end
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_resolve();
    test_backpressure();
    test_overflow();
    test_len_zero();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
